// File: rtl/robot_wheel_drive.sv
// robot_wheel_drive: soft-start two-wheel PWM driver with estop; define WHEEL_KICK_EN to load KICK_DUTY on start-up
module robot_wheel_drive #(
  parameter int PWM_W = 8,
  parameter int MAX_DUTY = 240,
  parameter int STEP = 16,
  parameter int RAMP_DIV = 1000,
  parameter int KICK_DUTY = 96
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             lw,
  input  logic             rw,
  input  logic             estop,
  output logic             left_pwm,
  output logic             right_pwm,
  output logic [PWM_W-1:0] left_duty,
  output logic [PWM_W-1:0] right_duty,
  output logic [1:0]       left_state,
  output logic [1:0]       right_state,
  output logic             ramp_tick
);
  localparam int DIV_W = $clog2(RAMP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [PWM_W:0] STEP_X = (PWM_W+1)'(STEP);
  localparam logic [PWM_W:0] MAX_X = (PWM_W+1)'(MAX_DUTY);
  localparam logic [PWM_W-1:0] MAX_D = PWM_W'(MAX_DUTY);
  localparam logic [PWM_W-1:0] KICK_D = PWM_W'(KICK_DUTY);
`ifdef WHEEL_KICK_EN
  localparam logic KICK_EN = 1'b1;
`else
  localparam logic KICK_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, UP, CRUISE, DOWN} state_t;
  logic [DIV_W-1:0] div_cnt;
  logic [PWM_W-1:0] pwm_cnt;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cnt   <= '0;
      pwm_cnt   <= '0;
      ramp_tick <= 1'b0;
    end else begin
      div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      pwm_cnt   <= pwm_cnt + 1'b1;
      ramp_tick <= div_cnt == DIV_LAST;
    end
  end
  for (genvar w = 0; w < 2; w++) begin : g_wheel
    state_t           st;
    logic [PWM_W-1:0] duty, up_d, dn_d;
    logic [PWM_W:0]   up_x;
    logic             cmd, pwm;
    assign cmd  = (w == 1) ? rw : lw;
    assign up_x = {1'b0, duty} + STEP_X;
    assign up_d = (up_x >= MAX_X) ? MAX_D : up_x[PWM_W-1:0];
    assign dn_d = ({1'b0, duty} > STEP_X) ? duty - STEP_X[PWM_W-1:0] : '0;
    always_ff @(posedge clk) begin
      pwm <= resetn && (pwm_cnt < duty);
      if (!resetn || estop) begin
        st   <= IDLE;
        duty <= '0;
      end else begin
        case (st)
          IDLE: begin
            duty <= (cmd && KICK_EN) ? KICK_D : '0;
            if (cmd) st <= UP;
          end
          UP: begin
            if (!cmd) st <= DOWN;
            else if (ramp_tick) begin
              duty <= up_d;
              if (up_d == MAX_D) st <= CRUISE;
            end
          end
          CRUISE: begin
            duty <= MAX_D;
            if (!cmd) st <= DOWN;
          end
          default: begin
            if (cmd) st <= UP;
            else if (ramp_tick) begin
              duty <= dn_d;
              if (dn_d == '0) st <= IDLE;
            end
          end
        endcase
      end
    end
  end
  assign left_pwm    = g_wheel[0].pwm;
  assign right_pwm   = g_wheel[1].pwm;
  assign left_duty   = g_wheel[0].duty;
  assign right_duty  = g_wheel[1].duty;
  assign left_state  = g_wheel[0].st;
  assign right_state = g_wheel[1].st;
endmodule

// File: tb/tb_robot_wheel_drive.sv
// tb_robot_wheel_drive: scoreboard bench comparing robot_wheel_drive against a cycle-count behavioural model
module tb_robot_wheel_drive;
  localparam int RD = 4, MAXD = 240, STP = 16, KICK = 96;
`ifdef WHEEL_KICK_EN
  localparam bit KICK_ON = 1'b1;
`else
  localparam bit KICK_ON = 1'b0;
`endif
  logic clk = 0, resetn = 0, lw = 0, rw = 0, estop = 0;
  logic left_pwm, right_pwm, ramp_tick;
  logic [7:0] left_duty, right_duty;
  logic [1:0] left_state, right_state;
  int checks = 0, failures = 0;
  typedef struct packed {
    logic [1:0] ls, rs;
    logic [7:0] ld, rd;
    logic lp, rp, tk;
  } exp_t;
  exp_t q[$];
  int m_cyc, m_st[2], m_duty[2], m_pwm[2];

  robot_wheel_drive #(.RAMP_DIV(RD)) dut (
    .clk(clk), .resetn(resetn), .lw(lw), .rw(rw), .estop(estop),
    .left_pwm(left_pwm), .right_pwm(right_pwm),
    .left_duty(left_duty), .right_duty(right_duty),
    .left_state(left_state), .right_state(right_state),
    .ramp_tick(ramp_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // m_cyc counts edges since reset; the tick and PWM counter are functions of it
  task automatic model_step();
    bit tick;
    int c;
    exp_t e;
    if (!resetn) begin
      m_cyc = 0;
      m_st = '{0, 0};
      m_duty = '{0, 0};
      m_pwm = '{0, 0};
    end else begin
      tick = (m_cyc > 0) && (m_cyc % RD == 0);
      for (int w = 0; w < 2; w++) begin
        c = w ? int'(rw) : int'(lw);
        m_pwm[w] = ((m_cyc % 256) < m_duty[w]) ? 1 : 0;
        if (estop) begin
          m_st[w] = 0;
          m_duty[w] = 0;
        end else if (m_st[w] == 0) begin
          if (c != 0) begin
            m_st[w] = 1;
            m_duty[w] = KICK_ON ? KICK : 0;
          end
        end else if (m_st[w] == 1) begin
          if (c == 0) m_st[w] = 3;
          else if (tick) begin
            m_duty[w] = (m_duty[w] + STP > MAXD) ? MAXD : m_duty[w] + STP;
            if (m_duty[w] == MAXD) m_st[w] = 2;
          end
        end else if (m_st[w] == 2) begin
          if (c == 0) m_st[w] = 3;
        end else begin
          if (c != 0) m_st[w] = 1;
          else if (tick) begin
            m_duty[w] = (m_duty[w] > STP) ? m_duty[w] - STP : 0;
            if (m_duty[w] == 0) m_st[w] = 0;
          end
        end
      end
      m_cyc++;
    end
    e.ls = 2'(m_st[0]);
    e.rs = 2'(m_st[1]);
    e.ld = 8'(m_duty[0]);
    e.rd = 8'(m_duty[1]);
    e.lp = m_pwm[0][0];
    e.rp = m_pwm[1][0];
    e.tk = (m_cyc > 0) && (m_cyc % RD == 0);
    q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("left_state", left_state, e.ls);
        chk("right_state", right_state, e.rs);
        chk("left_duty", left_duty, e.ld);
        chk("right_duty", right_duty, e.rd);
        chk("left_pwm", left_pwm, e.lp);
        chk("right_pwm", right_pwm, e.rp);
        chk("ramp_tick", ramp_tick, e.tk);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k, hi, rbusy, tgt;
    cyc(3);
    chk("rst_left_duty", left_duty, 0);
    chk("rst_left_state", left_state, 0);
    chk("rst_tick", ramp_tick, 0);
    resetn = 1;
    lw = 1;
    rbusy = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(1);
      rbusy += int'(right_pwm) + int'(right_duty != 0);
    end
    chk("right_quiet", rbusy, 0);
    chk("cruise_state", left_state, 2);
    chk("cruise_duty", left_duty, MAXD);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      hi += int'(left_pwm);
    end
    chk("pwm_highs", hi, MAXD);
    lw = 0;
    cyc(1);
    chk("drop_state", left_state, 3);
    chk("drop_duty", left_duty, MAXD);
    cyc(80);
    chk("down_state", left_state, 0);
    chk("down_duty", left_duty, 0);
    tgt = KICK_ON ? KICK + STP : 4 * STP;
    lw = 1;
    k = 0;
    while (!(left_duty == 8'(tgt) && ramp_tick) && k < 200) begin
      cyc(1);
      k++;
    end
    chk("reach_target_timeout", int'(k < 200), 1);
    lw = 0;
    cyc(1);
    chk("rev_state", left_state, 3);
    chk("rev_duty", left_duty, tgt);
    k = 0;
    while (!ramp_tick && k < 20) begin
      cyc(1);
      k++;
    end
    chk("rev_tick_timeout", int'(k < 20), 1);
    cyc(1);
    chk("rev_next_duty", left_duty, tgt - STP);
    cyc(80);
    lw = 1;
    rw = 1;
    cyc(80);
    chk("both_cruise_l", left_state, 2);
    chk("both_cruise_r", right_state, 2);
    estop = 1;
    cyc(1);
    chk("estop_lstate", left_state, 0);
    chk("estop_rstate", right_state, 0);
    chk("estop_lduty", left_duty, 0);
    chk("estop_rduty", right_duty, 0);
    cyc(1);
    chk("estop_lpwm", left_pwm, 0);
    chk("estop_rpwm", right_pwm, 0);
    cyc(8);
    estop = 0;
    cyc(1);
    chk("restart_state", left_state, 1);
    chk("restart_duty", left_duty, KICK_ON ? KICK : 0);
    cyc(20);
    resetn = 0;
    cyc(1);
    chk("midrst_lduty", left_duty, 0);
    chk("midrst_rduty", right_duty, 0);
    chk("midrst_lstate", left_state, 0);
    chk("midrst_tick", ramp_tick, 0);
    resetn = 1;
    lw = 0;
    rw = 0;
    cyc(2);
`ifdef WHEEL_KICK_EN
    rw = 1;
    cyc(1);
    chk("kick_duty", right_duty, KICK);
    k = 0;
    while (!ramp_tick && k < 20) begin
      cyc(1);
      k++;
    end
    cyc(1);
    chk("kick_next_duty", right_duty, KICK + STP);
`endif
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(47) == 0) lw = ~lw;
      if ($urandom_range(47) == 0) rw = ~rw;
      estop = estop ? ($urandom_range(3) != 0) : ($urandom_range(299) == 0);
      resetn = ($urandom_range(599) != 0);
      cyc(1);
    end
    resetn = 1;
    estop = 0;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/robot_wheel_drive.md
# robot_wheel_drive

Per-wheel soft-start motor driver that consumes the left/right wheel forward commands (`lw`, `rw`) produced by the robot steering logic and turns them into ramped PWM signals for the two wheel motors. Each wheel has its own ramp state machine, so duty rises and falls in fixed steps instead of switching abruptly. A shared prescaler paces the ramp and a shared free-running counter generates the PWM. An emergency stop overrides both wheels.

## Interface
Parameters:
- `PWM_W`, 8: width of the PWM counter and duty registers.
- `MAX_DUTY`, 240: cruise duty. Must be ≤ 2^PWM_W−1.
- `STEP`, 16: duty change per ramp tick. Must be ≥ 1.
- `RAMP_DIV`, 1000: clocks per ramp tick. Must be ≥ 2.
- `KICK_DUTY`, 96: start-up duty used only when `WHEEL_KICK_EN` is defined. Must be ≤ MAX_DUTY.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  synchronous, active-low reset.
- `lw`  in  1  left wheel forward command (1 = drive).
- `rw`  in  1  right wheel forward command.
- `estop`  in  1  emergency stop, level-sensitive, highest priority.
- `left_pwm`  out  1  left motor PWM.
- `right_pwm`  out  1  right motor PWM.
- `left_duty`  out  PWM_W  current left duty.
- `right_duty`  out  PWM_W  current right duty.
- `left_state`  out  2  left FSM state.
- `right_state`  out  2  right FSM state.
- `ramp_tick`  out  1  one-cycle ramp strobe.

## Operation
- Prescaler `div_cnt`:
  - Counts 0..RAMP_DIV−1, then wraps to 0.
  - `ramp_tick` = 1 (registered) in the cycle after `div_cnt` == RAMP_DIV−1, so it fires once every RAMP_DIV clocks.
- PWM counter `pwm_cnt`:
  - Free-running, PWM_W bits, wraps 2^PWM_W−1 → 0.
  - `x_pwm` <= (`pwm_cnt` < `x_duty`).
  - Duty 0 gives a constant low. Duty D gives D high cycles per 2^PWM_W period.
- Per-wheel FSM. The encoding is the `x_state` output value. `cmd` is `lw` or `rw`.
  - IDLE (0): duty = 0. If cmd = 1 → UP.
  - UP (1):
    - If cmd = 0 → DOWN, with duty unchanged this cycle. This takes priority over a ramp tick.
    - Otherwise, on each ramp tick: duty <= min(duty+STEP, MAX_DUTY). If the new duty equals MAX_DUTY → CRUISE.
  - CRUISE (2): duty = MAX_DUTY. If cmd = 0 → DOWN.
  - DOWN (3):
    - If cmd = 1 → UP, with duty unchanged this cycle. This takes priority over a ramp tick.
    - Otherwise, on each ramp tick: duty <= (duty > STEP) ? duty−STEP : 0. If the new duty is 0 → IDLE.
- Arithmetic is done in PWM_W+1 bits and saturates at both ends. The duty never wraps.
- `estop` = 1: both FSMs go to IDLE and both duties to 0 on the same edge, and stay there while `estop` is held. The prescaler and PWM counter keep running.
- When `estop` is released with cmd = 1, the wheel restarts from IDLE → UP, i.e. a full ramp.
- The two wheels are fully independent apart from the shared tick and counter.

## Timing
- Reset (`resetn` = 0 at an edge):
  - `div_cnt`, `pwm_cnt`, both duties, `x_pwm` and `ramp_tick` = 0.
  - Both states = IDLE.
  - Reset in the middle of a ramp aborts it immediately, with no ramp-down.
- Command to state change: 1 clock. `lw`/`rw`/`estop` are sampled at each edge.
- State and duty update on the same edge.
- Duty to PWM: one registered stage. `x_pwm` reflects `pwm_cnt`/`x_duty` from the previous cycle.
- Full ramp 0 → MAX_DUTY with defaults: 15 ticks = 15×RAMP_DIV clocks (without kick).
- When STEP does not divide MAX_DUTY, the last up-step is clamped to MAX_DUTY and the last down-step to 0.

## Configuration
- `WHEEL_KICK_EN` defined:
  - On the IDLE → UP transition, duty is loaded with KICK_DUTY on the same edge.
  - Ramping then continues from KICK_DUTY.
  - A DOWN → UP reversal does not kick.
- `WHEEL_KICK_EN` undefined: duty stays 0 on entering UP and first rises on the next ramp tick.

## Test plan
Run with RAMP_DIV = 4, defaults otherwise, and no kick unless stated.
- Reset, then hold `lw` = 1, `rw` = 0:
  - `left_duty` steps 16, 32 … 240, once every 4 clocks.
  - `left_state` reaches 2 after 15 ticks.
  - `right_duty` stays 0 and `right_pwm` stays low.
- In CRUISE, drop `lw`:
  - `left_state` = 3 one clock later.
  - Duty falls 240, 224 … 0 per tick, then state = 0.
- Raise `lw` at duty 64 in UP, drop it in the same cycle as a `ramp_tick`:
  - State → 3 with duty still 64.
  - The next tick gives 48.
- Both wheels cruising, then `estop` = 1 for 10 clocks:
  - Both duties = 0 and states = 0 on the next edge, and `x_pwm` is low from the following clock.
  - After release with commands still high, both restart the ramp from 0.
- Duty 240: count `left_pwm` highs over 256 clocks; the count is 240.
- With `WHEEL_KICK_EN` and `rw` 0 → 1 from IDLE:
  - `right_duty` = 96 one clock later.
  - The next tick gives 112.
  - Asserting `resetn` = 0 mid-ramp clears everything to 0 on the next edge.
